hex_display_bank: RTL and testbench

Parametrised bank of 7-segment display registers for the DE-series HEX displays. Each digit is written by address, either as a raw active-low segment pattern or as a 4-bit value decoded to a hex glyph. Adds per-digit blinking and whole-bank rotate-scroll, both timed by internal tick dividers. Sits between board-level switch/key logic or a CPU-style write port and the HEX pins.

---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex_tick_gen.sv | 33 +++
 rtl/hex_display_bank.sv | 102 ++++++++++
 tb/tb_hex_display_bank.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display bank.
//   seg_t       : one 7-segment pattern, bit0=a .. bit6=g, active-low
//   SEG_BLANK   : all segments off
//   HEX_GLYPH   : active-low glyphs for nibble values 0..F
//   hex_to_seg  : nibble -> glyph lookup
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// Modulo-DIV counter producing a one-cycle TICK on the cycle it wraps.
//   CLOCK : system clock
//   RESET : synchronous active-high reset, clears the count
//   EN    : count enable; while low the count is held at zero so the next
//           interval starts fresh when EN returns
//   TICK  : high for the single cycle in which the count wraps to zero
module hex_tick_gen #(
  parameter int DIV = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign TICK = EN && (count == LAST);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count <= '0;
    end else if (!EN || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_bank.sv
// Bank of addressable 7-segment digit registers with blink and rotate-scroll.
//   CLOCK, RESET : clock and synchronous active-high reset
//   WR_EN/WR_ADDR/WR_DATA/WR_DECODE : single write port; WR_DECODE selects
//                  glyph decode of WR_DATA[3:0] versus raw segment storage
//   BLINK_MASK   : per-digit blink enable
//   SCROLL_EN    : rotate the bank toward higher index on every scroll tick
//   HEX          : digit i on HEX[7*i+6:7*i], active-low
//   WR_ERR       : one-cycle pulse after a write to a nonexistent digit
//   BLINK_PHASE  : 1 while blinking digits are blanked
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 3,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    WR_EN,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [6:0]              WR_DATA,
  input  logic                    WR_DECODE,
  input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
  input  logic                    SCROLL_EN,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    WR_ERR,
  output logic                    BLINK_PHASE
);

  seg_t digit_q [NUM_DIGITS];
  seg_t digit_d [NUM_DIGITS];
  seg_t wr_seg;
  logic addr_ok;
  logic blink_tick;
  logic scroll_tick;
  logic blink_phase_q;
  logic wr_err_q;

  hex_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .EN    (1'b1),
    .TICK  (blink_tick)
  );

  hex_tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .EN    (SCROLL_EN),
    .TICK  (scroll_tick)
  );

  assign wr_seg  = WR_DECODE ? hex_to_seg(WR_DATA[3:0]) : WR_DATA;
  assign addr_ok = int'(WR_ADDR) < NUM_DIGITS;

  // Rotation is applied first so a coinciding write lands at its index in
  // post-rotation order and overrides whatever rotated into that slot.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (scroll_tick) begin
      digit_d[0] = digit_q[NUM_DIGITS-1];
      for (int i = 1; i < NUM_DIGITS; i++) begin
        digit_d[i] = digit_q[i-1];
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (WR_EN && addr_ok && (WR_ADDR == ADDR_W'(i))) begin
        digit_d[i] = wr_seg;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= SEG_BLANK;
      end
      blink_phase_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
      if (blink_tick) begin
        blink_phase_q <= ~blink_phase_q;
      end
      wr_err_q <= WR_EN && !addr_ok;
    end
  end

  // Blanking is applied only on the way out; stored patterns are untouched.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
    assign HEX[7*g +: 7] = (BLINK_MASK[g] && blink_phase_q) ? SEG_BLANK : digit_q[g];
  end

  assign WR_ERR      = wr_err_q;
  assign BLINK_PHASE = blink_phase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
module tb_hex_display_bank;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [2:0]  WR_ADDR = '0;
  logic [6:0]  WR_DATA = '0;
  logic        WR_DECODE = 1'b0;
  logic [5:0]  BLINK_MASK = '0;
  logic        SCROLL_EN = 1'b0;
  logic [41:0] HEX;
  logic        WR_ERR;
  logic        BLINK_PHASE;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // non-reset edges since the last reset edge
  logic [41:0] exp_hex;

  localparam logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  hex_display_bank #(
    .NUM_DIGITS (6),
    .ADDR_W     (3),
    .BLINK_DIV  (4),
    .SCROLL_DIV (8)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .WR_DECODE   (WR_DECODE),
    .BLINK_MASK  (BLINK_MASK),
    .SCROLL_EN   (SCROLL_EN),
    .HEX         (HEX),
    .WR_ERR      (WR_ERR),
    .BLINK_PHASE (BLINK_PHASE)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    if (RESET) n <= 0;
    else       n <= n + 1;
  end

  // Digits holding glyphs 0..5 after k rotations toward higher index.
  function automatic logic [41:0] rot_exp(input int k);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = GL[(((i - k) % 6) + 6) % 6];
    end
    return r;
  endfunction

  task automatic step(input int cycles);
    repeat (cycles) @(negedge CLOCK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d, input logic dec);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d; WR_DECODE = dec;
    @(negedge CLOCK);
    WR_EN = 1'b0;
  endtask

  task automatic load_0_to_5();
    for (int i = 0; i < 6; i++) wr(3'(i), 7'(i), 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (HEX !== ALL_BLANK) begin
      bad++; $display("FAIL reset_hex got=%h exp=%h", HEX, ALL_BLANK);
    end
    total++;
    if (BLINK_PHASE !== 1'b0) begin
      bad++; $display("FAIL reset_phase got=%b exp=0", BLINK_PHASE);
    end
    total++;
    if (WR_ERR !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b exp=0", WR_ERR);
    end
  endtask

  task automatic test_write();
    do_reset();
    exp_hex = ALL_BLANK;
    wr(3'd0, 7'h5A, 1'b1);          // upper bits ignored when decoding
    exp_hex[6:0] = 7'h08;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL write_d0 got=%h exp=%h", HEX, exp_hex);
    end
    wr(3'd1, 7'h12, 1'b0);
    exp_hex[13:7] = 7'h12;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL write_d1_raw got=%h exp=%h", HEX, exp_hex);
    end
    total++;
    if (WR_ERR !== 1'b0) begin
      bad++; $display("FAIL write_valid_err got=%b exp=0", WR_ERR);
    end
    wr(3'd5, 7'h70, 1'b1);
    exp_hex[41:35] = 7'h40;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL write_d5 got=%h exp=%h", HEX, exp_hex);
    end
  endtask

  task automatic test_wr_err();
    for (int a = 6; a < 8; a++) begin
      wr(3'(a), 7'h00, 1'b0);
      total++;
      if (WR_ERR !== 1'b1) begin
        bad++; $display("FAIL wr_err_pulse addr=%0d got=%b exp=1", a, WR_ERR);
      end
      total++;
      if (HEX !== exp_hex) begin
        bad++; $display("FAIL wr_err_hex addr=%0d got=%h exp=%h", a, HEX, exp_hex);
      end
      step(1);
      total++;
      if (WR_ERR !== 1'b0) begin
        bad++; $display("FAIL wr_err_clear addr=%0d got=%b exp=0", a, WR_ERR);
      end
    end
  endtask

  task automatic test_blink();
    logic ph;
    int guard;
    do_reset();
    BLINK_MASK = 6'b000100;
    wr(3'd4, 7'h55, 1'b0);
    wr(3'd2, 7'h03, 1'b1);
    for (int c = 0; c < 20; c++) begin
      ph = ((n / 4) % 2) == 1;
      exp_hex = ALL_BLANK;
      exp_hex[34:28] = 7'h55;
      exp_hex[20:14] = ph ? 7'h7F : 7'h30;
      total++;
      if (BLINK_PHASE !== ph) begin
        bad++; $display("FAIL blink_phase n=%0d got=%b exp=%b", n, BLINK_PHASE, ph);
      end
      total++;
      if (HEX !== exp_hex) begin
        bad++; $display("FAIL blink_hex n=%0d got=%h exp=%h", n, HEX, exp_hex);
      end
      step(1);
    end
    guard = 0;
    while (((n / 4) % 2) != 1 && guard < 8) begin
      step(1);
      guard++;
    end
    BLINK_MASK = 6'b000000;
    #1;
    total++;
    if (HEX[20:14] !== 7'h30 || BLINK_PHASE !== 1'b1) begin
      bad++; $display("FAIL blink_unmask got=%h/%b exp=30/1", HEX[20:14], BLINK_PHASE);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    load_0_to_5();
    total++;
    if (HEX !== rot_exp(0)) begin
      bad++; $display("FAIL scroll_load got=%h exp=%h", HEX, rot_exp(0));
    end
    SCROLL_EN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(7);
      total++;
      if (HEX !== rot_exp(k - 1)) begin
        bad++; $display("FAIL scroll_early k=%0d got=%h exp=%h", k, HEX, rot_exp(k - 1));
      end
      step(1);
      total++;
      if (HEX !== rot_exp(k)) begin
        bad++; $display("FAIL scroll_step k=%0d got=%h exp=%h", k, HEX, rot_exp(k));
      end
    end
    step(3);
    SCROLL_EN = 1'b0;
    step(2);
    SCROLL_EN = 1'b1;
    step(7);
    total++;
    if (HEX !== rot_exp(0)) begin
      bad++; $display("FAIL scroll_restart_early got=%h exp=%h", HEX, rot_exp(0));
    end
    step(1);
    total++;
    if (HEX !== rot_exp(1)) begin
      bad++; $display("FAIL scroll_restart got=%h exp=%h", HEX, rot_exp(1));
    end
    SCROLL_EN = 1'b0;
  endtask

  task automatic test_collision_and_reset();
    do_reset();
    load_0_to_5();
    SCROLL_EN = 1'b1;
    step(7);
    wr(3'd0, 7'h0F, 1'b1);          // lands on the scroll-tick edge
    exp_hex = rot_exp(1);
    exp_hex[6:0] = 7'h0E;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL collide_hex got=%h exp=%h", HEX, exp_hex);
    end
    step(3);
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    total++;
    if (HEX !== ALL_BLANK) begin
      bad++; $display("FAIL midscroll_reset got=%h exp=%h", HEX, ALL_BLANK);
    end
    wr(3'd0, 7'h01, 1'b1);
    step(6);
    exp_hex = ALL_BLANK;
    exp_hex[6:0] = 7'h79;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL post_reset_early got=%h exp=%h", HEX, exp_hex);
    end
    step(1);
    exp_hex = ALL_BLANK;
    exp_hex[13:7] = 7'h79;
    total++;
    if (HEX !== exp_hex) begin
      bad++; $display("FAIL post_reset_rotate got=%h exp=%h", HEX, exp_hex);
    end
    SCROLL_EN = 1'b0;
  endtask

  initial begin
    @(negedge CLOCK);
    test_reset();
    test_write();
    test_wr_err();
    test_blink();
    test_scroll();
    test_collision_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
